// File: rtl/ex_stage.sv
// Execute stage of a 5-stage RISC-V pipeline: operand forwarding, ALU, branch/jump
// resolution and an iterative shift-add multiplier feeding the EX/MEM register.
module ex_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            MemtoReg,
  input  logic                  RegWrite,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic                  MemSize,
  input  logic [2:0]            Branch,
  input  logic [3:0]            ALUOp,
  input  logic [1:0]            ALUSrc,
  input  logic [ADDR_WIDTH-1:0] PC_in,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic [4:0]            rd_addr,
  input  logic [4:0]            exmem_rd,
  input  logic [4:0]            memwb_rd,
  input  logic                  exmem_regwrite,
  input  logic                  memwb_regwrite,
  input  logic [DATA_WIDTH-1:0] exmem_data,
  input  logic [DATA_WIDTH-1:0] memwb_data,
  output logic                  stall_req,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [1:0]            MemtoReg_out,
  output logic                  RegWrite_out,
  output logic                  MemWrite_out,
  output logic                  MemRead_out,
  output logic                  MemSize_out,
  output logic [DATA_WIDTH-1:0] alu_result_out,
  output logic [DATA_WIDTH-1:0] store_data_out,
  output logic [4:0]            rd_addr_out
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_mul_a;
  logic [DATA_WIDTH-1:0] r_mul_b;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CW-1:0]         r_count;

  logic [DATA_WIDTH-1:0] w_rs1_fwd;
  logic [DATA_WIDTH-1:0] w_rs2_fwd;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_link;
  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] w_jalr_sum;
  logic [ADDR_WIDTH-1:0] w_br_target;
  logic [ADDR_WIDTH-1:0] w_jalr_target;
  logic [4:0]            w_shamt;
  logic                  w_taken;
  logic                  w_is_mul;
  logic                  w_is_jump;

  // Forwarding: EX/MEM beats MEM/WB, and x0 is never forwarded.
  always_comb begin
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs1_addr)) begin
      w_rs1_fwd = exmem_data;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs1_addr)) begin
      w_rs1_fwd = memwb_data;
    end else begin
      w_rs1_fwd = rs1_data;
    end
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs2_addr)) begin
      w_rs2_fwd = exmem_data;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs2_addr)) begin
      w_rs2_fwd = memwb_data;
    end else begin
      w_rs2_fwd = rs2_data;
    end
  end

  assign w_op_a  = ALUSrc[1] ? DATA_WIDTH'(PC_in) : w_rs1_fwd;
  assign w_op_b  = ALUSrc[0] ? imm : w_rs2_fwd;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu = '0;
    case (ALUOp)
      ALU_ADD:   w_alu = w_op_a + w_op_b;
      ALU_SUB:   w_alu = w_op_a - w_op_b;
      ALU_AND:   w_alu = w_op_a & w_op_b;
      ALU_OR:    w_alu = w_op_a | w_op_b;
      ALU_XOR:   w_alu = w_op_a ^ w_op_b;
      ALU_SLL:   w_alu = w_op_a << w_shamt;
      ALU_SRL:   w_alu = w_op_a >> w_shamt;
      ALU_SRA:   w_alu = $signed(w_op_a) >>> w_shamt;
      ALU_SLT:   w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLTU:  w_alu = {{(DATA_WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
      ALU_PASSB: w_alu = w_op_b;
      ALU_MUL:   w_alu = r_acc;
      default:   w_alu = w_op_a + w_op_b;
    endcase
  end

  assign w_is_mul      = (ALUOp == ALU_MUL);
  assign w_is_jump     = (Branch == 3'b110) || (Branch == 3'b111);
  assign w_link        = DATA_WIDTH'(PC_in) + DATA_WIDTH'(32'd4);
  assign w_result      = w_is_jump ? w_link : w_alu;
  assign w_br_target   = PC_in + ADDR_WIDTH'(imm);
  assign w_jalr_sum    = w_rs1_fwd + imm;
  assign w_jalr_target = ADDR_WIDTH'(w_jalr_sum);

  // Branch condition evaluated on forwarded register operands, not on ALU inputs.
  always_comb begin
    w_taken = 1'b0;
    case (Branch)
      3'b001:  w_taken = (w_rs1_fwd == w_rs2_fwd);
      3'b010:  w_taken = (w_rs1_fwd != w_rs2_fwd);
      3'b011:  w_taken = ($signed(w_rs1_fwd) < $signed(w_rs2_fwd));
      3'b100:  w_taken = ($signed(w_rs1_fwd) >= $signed(w_rs2_fwd));
      3'b101:  w_taken = (w_rs1_fwd < w_rs2_fwd);
      3'b110:  w_taken = 1'b1;
      3'b111:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign redirect    = w_taken && !flush && !reset;
  assign redirect_pc = (Branch == 3'b111) ? {w_jalr_target[ADDR_WIDTH-1:1], 1'b0} : w_br_target;
  assign stall_req   = (w_is_mul && (r_state != S_DONE) && !flush) || (r_state == S_RUN);

  // Multiplier sequencer: IDLE latches operands, RUN does one shift-add per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul && !flush) begin
            r_mul_a <= w_op_a;
            r_mul_b <= w_op_b;
            r_acc   <= '0;
            r_count <= CW'(MUL_CYCLES);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_mul_b[0]) begin
              r_acc <= r_acc + r_mul_a;
            end
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM register; a stalled or flushed cycle inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush || stall_req) begin
      MemtoReg_out   <= 2'b00;
      RegWrite_out   <= 1'b0;
      MemWrite_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      MemSize_out    <= 1'b1;
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_addr_out    <= 5'd0;
    end else begin
      MemtoReg_out   <= MemtoReg;
      RegWrite_out   <= RegWrite;
      MemWrite_out   <= MemWrite;
      MemRead_out    <= MemRead;
      MemSize_out    <= MemSize;
      alu_result_out <= w_result;
      store_data_out <= w_rs2_fwd;
      rd_addr_out    <= rd_addr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and compared after the capturing clock edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [1:0]  MemtoReg;
  logic        RegWrite, MemWrite, MemRead, MemSize;
  logic [2:0]  Branch;
  logic [3:0]  ALUOp;
  logic [1:0]  ALUSrc;
  logic [31:0] PC_in, rs1_data, rs2_data, imm, exmem_data, memwb_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd;
  logic        exmem_regwrite, memwb_regwrite;
  logic        stall_req, redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  MemtoReg_out;
  logic        RegWrite_out, MemWrite_out, MemRead_out, MemSize_out;
  logic [31:0] alu_result_out, store_data_out;
  logic [4:0]  rd_addr_out;

  int tests = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [1:0]  m2r;
    logic        rw;
    logic        mw;
    logic        mr;
    logic        ms;
  } exmem_t;

  exmem_t exp_q[$];

  ex_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .MemSize(MemSize),
    .Branch(Branch), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .PC_in(PC_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_data(exmem_data), .memwb_data(memwb_data),
    .stall_req(stall_req), .redirect(redirect), .redirect_pc(redirect_pc),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .MemWrite_out(MemWrite_out),
    .MemRead_out(MemRead_out), .MemSize_out(MemSize_out),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_addr_out(rd_addr_out)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    flush = 1'b0; MemtoReg = 2'b00; RegWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; MemSize = 1'b0;
    Branch = 3'b000; ALUOp = 4'd0; ALUSrc = 2'b00; PC_in = 32'h0;
    rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
    exmem_rd = 5'd0; memwb_rd = 5'd0; exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    exmem_data = 32'h0; memwb_data = 32'h0;
  endtask

  task automatic push_bubble();
    exmem_t e;
    e = '{alu: 32'h0, sd: 32'h0, rd: 5'd0, m2r: 2'b00, rw: 1'b0, mw: 1'b0, mr: 1'b0, ms: 1'b1};
    exp_q.push_back(e);
  endtask

  // Expected result for the instruction currently driven; control comes from the stimulus.
  task automatic push_pass(input logic [31:0] alu, input logic [31:0] sd);
    exmem_t e;
    e = '{alu: alu, sd: sd, rd: rd_addr, m2r: MemtoReg, rw: RegWrite, mw: MemWrite, mr: MemRead, ms: MemSize};
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exmem_t e;
    if (exp_q.size() == 0) begin
      tests++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check32({tag, "_alu"}, alu_result_out, e.alu);
      check32({tag, "_sd"}, store_data_out, e.sd);
      check32({tag, "_rd"}, {27'd0, rd_addr_out}, {27'd0, e.rd});
      check32({tag, "_m2r"}, {30'd0, MemtoReg_out}, {30'd0, e.m2r});
      check1({tag, "_rw"}, RegWrite_out, e.rw);
      check1({tag, "_mw"}, MemWrite_out, e.mw);
      check1({tag, "_mr"}, MemRead_out, e.mr);
      check1({tag, "_ms"}, MemSize_out, e.ms);
    end
  endtask

  task automatic alu_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    set_defaults();
    ALUOp = op; rs1_data = a; rs2_data = b; rs1_addr = 5'd10; rs2_addr = 5'd11;
    rd_addr = 5'd12; RegWrite = 1'b1;
    push_pass(exp, b);
    tick();
    pop_check(tag);
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    set_defaults();
    ALUOp = 4'd11; rs1_addr = 5'd6; rs2_addr = 5'd7; rs1_data = a; rs2_data = b;
    rd_addr = 5'd8; RegWrite = 1'b1;
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    start_mul(a, b);
    for (int i = 0; i < 33; i++) begin
      #1;
      check1({tag, "_stall"}, stall_req, 1'b1);
      push_bubble();
      tick();
      pop_check({tag, "_bubble"});
    end
    #1;
    check1({tag, "_stall_done"}, stall_req, 1'b0);
    push_pass(exp, b);
    tick();
    pop_check(tag);
  endtask

  initial begin
    set_defaults();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check32("rst_alu", alu_result_out, 32'h0);
    check1("rst_ms", MemSize_out, 1'b1);
    check1("rst_rw", RegWrite_out, 1'b0);
    check1("rst_stall", stall_req, 1'b0);

    // ADD without forwarding, then with both forwarding paths hitting rs1
    set_defaults();
    rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd3; rs1_data = 32'd5; rs2_data = 32'd7; RegWrite = 1'b1;
    push_pass(32'd12, 32'd7);
    tick();
    pop_check("add");

    set_defaults();
    rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd3; rs1_data = 32'd5; rs2_data = 32'd7; RegWrite = 1'b1;
    exmem_rd = 5'd1; exmem_regwrite = 1'b1; exmem_data = 32'd100;
    memwb_rd = 5'd1; memwb_regwrite = 1'b1; memwb_data = 32'd200;
    push_pass(32'd107, 32'd7);
    tick();
    pop_check("fwd_exmem");

    set_defaults();
    rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd4; rs1_data = 32'd5; rs2_data = 32'd7; RegWrite = 1'b1;
    memwb_rd = 5'd2; memwb_regwrite = 1'b1; memwb_data = 32'd50; MemWrite = 1'b1; MemSize = 1'b1;
    push_pass(32'd55, 32'd50);
    tick();
    pop_check("fwd_memwb");

    set_defaults();
    rs1_addr = 5'd0; rs2_addr = 5'd2; rd_addr = 5'd4; rs1_data = 32'd3; rs2_data = 32'd4; RegWrite = 1'b1;
    exmem_rd = 5'd0; exmem_regwrite = 1'b1; exmem_data = 32'd999; MemtoReg = 2'b01; MemRead = 1'b1;
    push_pass(32'd7, 32'd4);
    tick();
    pop_check("fwd_x0");

    // Branches: taken BEQ, not-taken BEQ, flush gating, JALR
    set_defaults();
    Branch = 3'b001; ALUOp = 4'd1; PC_in = 32'h8000_0010; imm = 32'hFFFF_FFF0;
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = 32'd9; rs2_data = 32'd9;
    #1;
    check1("beq_redirect", redirect, 1'b1);
    check32("beq_target", redirect_pc, 32'h8000_0000);
    push_pass(32'd0, 32'd9);
    tick();
    pop_check("beq");

    rs2_data = 32'd8;
    #1;
    check1("beq_nt_redirect", redirect, 1'b0);
    push_pass(32'd1, 32'd8);
    tick();
    pop_check("beq_nt");

    rs2_data = 32'd9;
    flush = 1'b1;
    #1;
    check1("beq_flush_redirect", redirect, 1'b0);
    push_bubble();
    tick();
    pop_check("beq_flush");

    set_defaults();
    Branch = 3'b111; ALUSrc = 2'b01; PC_in = 32'h8000_0010; imm = 32'd2;
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = 32'h8000_0101; rs2_data = 32'd8;
    rd_addr = 5'd1; RegWrite = 1'b1;
    #1;
    check1("jalr_redirect", redirect, 1'b1);
    check32("jalr_target", redirect_pc, 32'h8000_0102);
    push_pass(32'h8000_0014, 32'd8);
    tick();
    pop_check("jalr");

    // Multiplier: full run, zero multiplier, then flush in RUN cycle 10
    run_mul("mul_ff_3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run_mul("mul_zero", 32'd12345, 32'd0, 32'd0);
    run_mul("mul_mix", 32'd1234, 32'd5678, 32'd7006652);

    start_mul(32'd7, 32'd6);
    for (int i = 0; i < 10; i++) begin
      push_bubble();
      tick();
      pop_check("mulfl_bubble");
    end
    flush = 1'b1;
    #1;
    check1("mulfl_stall_in_flush", stall_req, 1'b1);
    push_bubble();
    tick();
    pop_check("mulfl_flush");
    set_defaults();
    rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd9; rs1_data = 32'd20; rs2_data = 32'd22; RegWrite = 1'b1;
    #1;
    check1("mulfl_stall_after", stall_req, 1'b0);
    push_pass(32'd42, 32'd22);
    tick();
    pop_check("mulfl_add");

    // Reset in the middle of a multiply
    start_mul(32'd3, 32'd5);
    for (int i = 0; i < 5; i++) begin
      push_bubble();
      tick();
      pop_check("mulrst_bubble");
    end
    reset = 1'b1;
    set_defaults();
    Branch = 3'b110; rd_addr = 5'd4; RegWrite = 1'b1;
    #1;
    check1("rst_redirect_gated", redirect, 1'b0);
    push_bubble();
    tick();
    pop_check("mulrst");
    reset = 1'b0;
    set_defaults();
    #1;
    check1("mulrst_stall", stall_req, 1'b0);

    // ALU corner cases
    alu_op("sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_op("sltu", 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd1);
    alu_op("slt", 4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0);
    alu_op("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_op("sll", 4'd5, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
    alu_op("srl", 4'd6, 32'h8000_0000, 32'd31, 32'h0000_0001);
    alu_op("xor", 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    alu_op("passb", 4'd10, 32'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    alu_op("op15_add", 4'd15, 32'hFFFF_FFFF, 32'd2, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
